// File: rtl/geofence_pkg.sv
// Shared constants and types for the geofence point driver.
package geofence_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned PTS_PER_OBJ = 7;
  localparam int unsigned WAIT_LIMIT  = 1023;
  localparam int unsigned WAIT_W      = 10;
  localparam int unsigned PT_IDX_W    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } gf_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/geofence_point_bank.sv
// One 7-point object buffer: fills in order, holds full until released.
module geofence_point_bank
  import geofence_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  point_t              wr_pt_i,
  input  logic                release_i,
  input  logic [PT_IDX_W-1:0] rd_idx_i,
  output point_t              rd_pt_o,
  output logic                full_o,
  output logic                last_wr_o
);

  point_t              mem_q [PTS_PER_OBJ];
  logic [PT_IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic                full_q, full_d;
  logic                wr_accept;

  assign wr_accept = wr_en_i && !full_q;
  assign last_wr_o = wr_accept && (wr_cnt_q == PT_IDX_W'(PTS_PER_OBJ - 1));
  assign full_o    = full_q;

  // Next fill count and full flag; release and completion never hit the same bank together.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    full_d   = full_q;
    if (release_i) begin
      full_d = 1'b0;
    end
    if (wr_accept) begin
      if (last_wr_o) begin
        wr_cnt_d = '0;
        full_d   = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + PT_IDX_W'(1);
      end
    end
  end

  // Fill count and full flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      full_q   <= full_d;
    end
  end

  // Point storage needs no reset: it is only read after a full fill.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_cnt_q] <= wr_pt_i;
    end
  end

  // Combinational read port for the stream side.
  always_comb begin
    rd_pt_o = '0;
    if (rd_idx_i < PT_IDX_W'(PTS_PER_OBJ)) begin
      rd_pt_o = mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/geofence_driver.sv
// Ping-pong buffered driver that streams 7-point objects to a geofence evaluator
// and returns one result (or timeout) per object.
module geofence_driver
  import geofence_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               gf_valid,
  input  logic               gf_is_inside,
  output logic               res_valid,
  output logic               res_inside,
  output logic               res_timeout,
  output logic [7:0]         res_index,
  output logic               busy,
  output logic               protocol_err
);

  gf_state_e           state_q;
  logic                wr_ptr_q, send_ptr_q;
  logic [PT_IDX_W-1:0] send_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                res_valid_q, res_inside_q, res_timeout_q, perr_q;
  logic [7:0]          res_index_q;

  logic [1:0]          bank_full, bank_last_wr, bank_wr_en, bank_release;
  point_t              bank_rd [2];
  point_t              in_pt;
  point_t              send_pt;
  logic                wait_end;

  assign in_pt    = '{x: in_x, y: in_y};
  assign in_ready = !bank_full[wr_ptr_q];
  // A same-cycle response beats the limit, so the limit only flags a timeout without gf_valid.
  assign wait_end = (state_q == StWait) && (gf_valid || (wait_cnt_q == WAIT_W'(WAIT_LIMIT)));

  // Route host writes to the write bank and the release to the send bank.
  always_comb begin
    bank_wr_en[0]   = in_valid && !wr_ptr_q;
    bank_wr_en[1]   = in_valid && wr_ptr_q;
    bank_release[0] = wait_end && !send_ptr_q;
    bank_release[1] = wait_end && send_ptr_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    geofence_point_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (bank_wr_en[b]),
      .wr_pt_i   (in_pt),
      .release_i (bank_release[b]),
      .rd_idx_i  (send_cnt_q),
      .rd_pt_o   (bank_rd[b]),
      .full_o    (bank_full[b]),
      .last_wr_o (bank_last_wr[b])
    );
  end

  // Write pointer flips to the other bank once the current one takes its last point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
    end else if (|bank_last_wr) begin
      wr_ptr_q <= ~wr_ptr_q;
    end
  end

  // Control FSM with registered result outputs and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      send_ptr_q    <= 1'b0;
      send_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      res_valid_q   <= 1'b0;
      res_inside_q  <= 1'b0;
      res_timeout_q <= 1'b0;
      res_index_q   <= '0;
      perr_q        <= 1'b0;
    end else begin
      res_valid_q   <= 1'b0;
      res_inside_q  <= 1'b0;
      res_timeout_q <= 1'b0;
      if (res_valid_q) begin
        res_index_q <= res_index_q + 8'd1;
      end
      if (gf_valid && (state_q != StWait)) begin
        perr_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bank_full[send_ptr_q]) begin
            state_q    <= StSend;
            send_cnt_q <= '0;
          end
        end
        StSend: begin
          if (send_cnt_q == PT_IDX_W'(PTS_PER_OBJ - 1)) begin
            state_q    <= StWait;
            wait_cnt_q <= '0;
          end else begin
            send_cnt_q <= send_cnt_q + PT_IDX_W'(1);
          end
        end
        StWait: begin
          if (wait_end) begin
            res_valid_q   <= 1'b1;
            res_inside_q  <= gf_valid && gf_is_inside;
            res_timeout_q <= !gf_valid;
            send_ptr_q    <= ~send_ptr_q;
            // Skip IDLE when the other bank is already waiting.
            if (bank_full[~send_ptr_q]) begin
              state_q    <= StSend;
              send_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stream the send bank only while sending; zeros otherwise.
  always_comb begin
    send_pt = bank_rd[send_ptr_q];
    X       = '0;
    Y       = '0;
    if (state_q == StSend) begin
      X = send_pt.x;
      Y = send_pt.y;
    end
  end

  assign busy         = (state_q != StIdle);
  assign res_valid    = res_valid_q;
  assign res_inside   = res_inside_q;
  assign res_timeout  = res_timeout_q;
  assign res_index    = res_index_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_geofence_driver.sv
module tb_geofence_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_x = '0, in_y = '0;
  logic [9:0] X, Y;
  logic       gf_valid = 1'b0, gf_is_inside = 1'b0;
  logic       res_valid, res_inside, res_timeout, busy, protocol_err;
  logic [7:0] res_index;

  geofence_driver dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .X            (X),
    .Y            (Y),
    .gf_valid     (gf_valid),
    .gf_is_inside (gf_is_inside),
    .res_valid    (res_valid),
    .res_inside   (res_inside),
    .res_timeout  (res_timeout),
    .res_index    (res_index),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  logic [9:0] fx [6] = '{10'd200, 10'd400, 10'd500, 10'd400, 10'd200, 10'd100};
  logic [9:0] fy [6] = '{10'd100, 10'd100, 10'd300, 10'd500, 10'd500, 10'd300};

  // Object-level reference model state.
  logic [19:0] part_q[$];
  logic [19:0] obj_pts[$];
  int          obj_c[$];
  bit          act;
  int          st, last_end, full_cnt, res_cnt;
  bit          rv_pend, e_in_q, e_to_q, perr_m;
  logic [7:0]  e_idx_q;

  // Responder settings and observations.
  int resp_delay, spur_ph;
  bit resp_in;
  int rv_t[$];
  int rv_idx[$];
  bit rv_in[$];
  bit rv_to[$];
  int acc_cnt, drop_acc, rise_t, t5050;

  typedef struct {
    bit         iv;
    logic [9:0] ix, iy;
    bit         gv, gi;
    bit         e_rdy, e_busy, e_rv, e_in;
    logic [9:0] e_x, e_y;
    logic [7:0] e_idx;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", nm, t, got, exp);
    end
  endtask

  function automatic int wph();
    return (act && t >= st + 7) ? t - st - 7 : -1;
  endfunction

  function automatic int sph();
    return (act && t >= st && t < st + 7) ? t - st : -1;
  endfunction

  task automatic model_reset();
    part_q.delete(); obj_pts.delete(); obj_c.delete();
    rv_t.delete(); rv_idx.delete(); rv_in.delete(); rv_to.delete();
    t = 0; act = 0; st = 0; last_end = -10; full_cnt = 0; res_cnt = 0;
    rv_pend = 0; perr_m = 0; resp_delay = -1; spur_ph = -1; resp_in = 0;
    acc_cnt = 0; drop_acc = -1; rise_t = -1; t5050 = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 0; in_x = '0; in_y = '0; gf_valid = 0; gf_is_inside = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_X", X, 0);
    chk("rst_Y", Y, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_inside", res_inside, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_res_index", res_index, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: compare against the model, drive inputs, advance the model.
  task automatic cyc(input bit iv, input logic [9:0] ix, input logic [9:0] iy,
                     input bit gv, input bit gi);
    bit         e_rdy, e_busy;
    logic [9:0] e_x, e_y;
    int         ph;
    e_rdy  = (full_cnt < 2);
    e_busy = act && (t >= st);
    ph     = t - st;
    e_x    = '0;
    e_y    = '0;
    if (e_busy && ph < 7) begin
      e_x = obj_pts[ph][19:10];
      e_y = obj_pts[ph][9:0];
    end
    chk("in_ready", in_ready, e_rdy);
    chk("busy", busy, e_busy);
    chk("X", X, e_x);
    chk("Y", Y, e_y);
    chk("res_valid", res_valid, rv_pend);
    chk("protocol_err", protocol_err, perr_m);
    if (rv_pend) begin
      chk("res_inside", res_inside, e_in_q);
      chk("res_timeout", res_timeout, e_to_q);
      chk("res_index", res_index, e_idx_q);
    end
    rv_pend = 0;
    if (res_valid) begin
      rv_t.push_back(t); rv_idx.push_back(int'(res_index));
      rv_in.push_back(res_inside); rv_to.push_back(res_timeout);
    end
    if (!in_ready && drop_acc < 0) drop_acc = acc_cnt;
    if (drop_acc >= 0 && rise_t < 0 && in_ready) rise_t = t;
    if (X == 10'd50 && Y == 10'd50 && t5050 < 0) t5050 = t;
    in_valid = iv; in_x = ix; in_y = iy; gf_valid = gv; gf_is_inside = gi;
    if (iv && in_ready) acc_cnt++;
    if (iv && e_rdy) begin
      part_q.push_back({ix, iy});
      if (part_q.size() == 7) begin
        foreach (part_q[i]) obj_pts.push_back(part_q[i]);
        part_q.delete();
        obj_c.push_back(t);
        full_cnt++;
      end
    end
    if (act && t >= st + 7) begin
      if (gv || (t - st - 7 == 1023)) begin
        e_in_q  = gv && gi;
        e_to_q  = !gv;
        e_idx_q = 8'(res_cnt);
        res_cnt++;
        rv_pend  = 1;
        last_end = t;
        act      = 0;
        full_cnt--;
        repeat (7) void'(obj_pts.pop_front());
        void'(obj_c.pop_front());
      end
    end else if (gv) begin
      perr_m = 1;
    end
    if (!act && obj_c.size() > 0) begin
      act = 1;
      st  = (last_end + 1 > obj_c[0] + 2) ? last_end + 1 : obj_c[0] + 2;
    end
    @(negedge clk);
    t++;
  endtask

  task automatic tick(input bit iv, input logic [9:0] ix, input logic [9:0] iy,
                      input bit spur);
    bit gv;
    gv = spur;
    if (wph() >= 0 && wph() == resp_delay) gv = 1;
    if (spur_ph >= 0 && sph() == spur_ph) gv = 1;
    cyc(iv, ix, iy, gv, resp_in);
  endtask

  task automatic send_obj(input logic [9:0] tx, input logic [9:0] ty);
    for (int i = 0; i < 7; i++) begin
      int         guard;
      bit         ok;
      logic [9:0] px, py;
      px = (i == 0) ? tx : fx[i-1];
      py = (i == 0) ? ty : fy[i-1];
      guard = 0;
      ok = 0;
      while (!ok && guard < 3000) begin
        ok = in_ready;
        tick(1, px, py, 0);
        guard++;
      end
      chk("send_obj_accept", ok, 1);
    end
    tick(0, '0, '0, 0);
  endtask

  task automatic wait_res(input int bound);
    int n;
    n = 0;
    while (!res_valid && n < bound) begin
      tick(0, '0, '0, 0);
      n++;
    end
    chk("res_arrives", res_valid, 1);
    tick(0, '0, '0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Single object, responder answers inside four cycles after the last streamed point.
    for (int i = 0; i < 21; i++) begin
      tbl[i] = '{iv: 0, ix: '0, iy: '0, gv: 0, gi: 0, e_rdy: 1, e_busy: 0, e_rv: 0,
                 e_in: 0, e_x: '0, e_y: '0, e_idx: '0};
    end
    for (int i = 0; i < 7; i++) begin
      tbl[i].iv = 1;
      tbl[i].ix = (i == 0) ? 10'd300 : fx[i-1];
      tbl[i].iy = (i == 0) ? 10'd300 : fy[i-1];
      tbl[i+8].e_busy = 1;
      tbl[i+8].e_x = tbl[i].ix;
      tbl[i+8].e_y = tbl[i].iy;
    end
    for (int i = 15; i < 19; i++) tbl[i].e_busy = 1;
    tbl[18].gv = 1; tbl[18].gi = 1;
    tbl[19].e_rv = 1; tbl[19].e_in = 1; tbl[19].e_idx = 8'd0;

    model_reset();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_X", X, tbl[i].e_x);
      chk("tbl_Y", Y, tbl[i].e_y);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_res_valid", res_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk("tbl_res_inside", res_inside, tbl[i].e_in);
        chk("tbl_res_index", res_index, tbl[i].e_idx);
      end
      in_valid = tbl[i].iv; in_x = tbl[i].ix; in_y = tbl[i].iy;
      gf_valid = tbl[i].gv; gf_is_inside = tbl[i].gi;
      @(negedge clk);
    end

    // Back-to-back objects: second SEND starts with the first result pulse.
    do_reset();
    resp_delay = 3; resp_in = 0;
    send_obj(10'd300, 10'd300);
    send_obj(10'd50, 10'd50);
    wait_res(100);
    wait_res(100);
    chk("b2b_results", rv_t.size(), 2);
    chk("b2b_no_gap", t5050, rv_t[0]);
    chk("b2b_index", rv_idx[1], 1);
    chk("b2b_inside", rv_in[1], 0);

    // Stalled responder with host always offering: fill both banks, then timeout.
    do_reset();
    n = 0;
    while (rv_t.size() == 0 && n < 1200) begin
      tick(1, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 0);
      n++;
    end
    chk("full_accepts", drop_acc, 14);
    chk("timeout_cycle", rv_t[0], 15 + 1024);
    chk("timeout_flag", rv_to[0], 1);
    chk("timeout_inside", rv_in[0], 0);
    chk("ready_rise", rise_t, rv_t[0]);

    // Response on the final counter value still counts as a response.
    do_reset();
    resp_delay = 1023; resp_in = 1;
    send_obj(10'd300, 10'd300);
    wait_res(1100);
    chk("tie_timeout", rv_to[0], 0);
    chk("tie_inside", rv_in[0], 1);

    // Stray gf_valid during SEND cycle 3.
    do_reset();
    resp_delay = 2; resp_in = 1; spur_ph = 3;
    send_obj(10'd300, 10'd300);
    wait_res(50);
    spur_ph = -1;
    repeat (5) tick(0, '0, '0, 0);
    chk("perr_sticky", protocol_err, 1);
    chk("perr_one_result", rv_t.size(), 1);

    // Reset mid-WAIT aborts the object; next object gets index 0.
    do_reset();
    send_obj(10'd300, 10'd300);
    n = 0;
    while (wph() != 5 && n < 100) begin
      tick(0, '0, '0, 0);
      n++;
    end
    chk("reached_wait", wph(), 5);
    do_reset();
    repeat (3) tick(0, '0, '0, 0);
    resp_delay = 1; resp_in = 1;
    send_obj(10'd50, 10'd50);
    wait_res(50);
    chk("post_reset_index", rv_idx[0], 0);

    // Randomized traffic against the model.
    do_reset();
    n = 0;
    while (rv_t.size() < 20 && n < 15000) begin
      if (sph() == 0) begin
        resp_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
        resp_in = 1'($urandom_range(0, 1));
      end
      tick($urandom_range(0, 3) != 0, 10'($urandom_range(0, 1023)),
           10'($urandom_range(0, 1023)), (wph() < 0) && ($urandom_range(0, 199) == 0));
      n++;
    end
    chk("rand_results", rv_t.size(), 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/geofence_driver.md
GEOFENCE_DRIVER -- requirements
Module: geofence_driver

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  host offers one point on in_x/in_y.
REQ-004 in_ready  output  1  driver accepts the offered point this cycle.
REQ-005 in_x, in_y  input  10 each  point coordinates, unsigned.
REQ-006 X, Y  output  10 each  point stream to the geofence evaluator.
REQ-007 gf_valid  input  1  evaluator result strobe.
REQ-008 gf_is_inside  input  1  evaluator result, qualified by gf_valid.
REQ-009 res_valid  output  1  one-cycle result pulse to the host.
REQ-010 res_inside  output  1  captured gf_is_inside, qualified by res_valid.
REQ-011 res_timeout  output  1  result ended by timeout, qualified by res_valid.
REQ-012 res_index  output  8  object sequence number, qualified by res_valid.
REQ-013 busy  output  1  high in SEND or WAIT.
REQ-014 protocol_err  output  1  sticky error: gf_valid seen outside WAIT.

Function
REQ-015 An object is 7 points: point 0 is the test point, and points 1-6 are the fence vertices in order.
REQ-016 Input handshake: a point transfers when in_valid and in_ready are both high on a clock edge.
REQ-017 Storage is two 7-point banks used ping-pong: one write bank (host side) and one send bank (stream side).
REQ-018 in_ready is high only when the current write bank is not full.
REQ-019 When the 7th point is written, the write bank is marked full and the write pointer toggles to the other bank.
REQ-020 FSM states are IDLE, SEND and WAIT.
REQ-021 IDLE -> SEND occurs on the cycle after a bank becomes full; that bank becomes the send bank.
REQ-022 SEND lasts exactly 7 cycles: on SEND cycle k (0..6), X/Y = point k of the send bank.
REQ-023 On the cycle after SEND cycle 6, the FSM enters WAIT.
REQ-024 Outside SEND, X and Y are 0.
REQ-025 In WAIT, a 10-bit counter increments every cycle.
REQ-026 WAIT ends on gf_valid=1 (capture gf_is_inside, res_timeout=0) or when the counter reaches 1023 (res_inside=0, res_timeout=1).
REQ-027 res_valid pulses for one cycle, on the cycle after WAIT ends; res_index is then incremented, wrapping 255 -> 0.
REQ-028 The send bank is released (marked empty) in the cycle WAIT ends.
REQ-029 If the other bank is full at that point, the FSM goes directly WAIT -> SEND; otherwise it goes to IDLE.
REQ-030 If gf_valid and the counter reaching 1023 occur in the same cycle, gf_valid wins: res_timeout=0.
REQ-031 A bank completing its 7th write and the send bank being released in the same cycle are both honoured; neither event is lost.
REQ-032 gf_valid in IDLE or SEND is ignored for results and sets protocol_err, which stays set until reset.
REQ-033 With both banks full, in_ready=0 until a release.
REQ-034 Throughput: back-to-back objects need no idle cycle between WAIT end and the next SEND cycle 0.

Reset
REQ-035 reset clears the FSM to IDLE, empties both banks and sets both bank pointers to bank 0.
REQ-036 reset zeroes the WAIT counter and res_index.
REQ-037 reset drives in_ready=1 and X=Y=0, and drives res_valid, res_inside, res_timeout, busy and protocol_err to 0.
REQ-038 reset asserted mid-SEND or mid-WAIT aborts the object with no res_valid pulse.

Structure
REQ-039 geofence_pkg holds: COORD_W=10, PTS_PER_OBJ=7, WAIT_LIMIT=1023, the FSM state enum, and the 20-bit point type {x,y}.
REQ-040 One sub-module, geofence_point_bank, holds 7x20 storage, a write counter, a full flag, a release input and a combinational read port; it is instantiated twice.

Verification
REQ-041 Load test point (300,300) and fence (200,100),(400,100),(500,300),(400,500),(200,500),(100,300); responder returns gf_valid=1, is_inside=1 four cycles after the last point -> X/Y show the 7 points on 7 consecutive cycles, then res_valid=1, res_inside=1, res_index=0.
REQ-042 Load two objects back-to-back (second test point (50,50)); responder returns is_inside=0 -> second SEND cycle 0 directly follows the first WAIT end, and the second result has res_inside=0, res_index=1.
REQ-043 Responder never asserts gf_valid -> res_valid occurs 1024 cycles after WAIT entry with res_timeout=1, res_inside=0.
REQ-044 Hold in_valid=1 continuously while the responder stalls -> in_ready drops after 14 accepted points and rises the cycle after the first release.
REQ-045 Pulse gf_valid during SEND cycle 3 -> protocol_err=1 and stays 1, with no res_valid from that pulse.
REQ-046 Assert reset during WAIT -> no res_valid, outputs at reset values, and a subsequent object is processed with res_index=0.
